// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: shift-add/restoring-divide MULT/DIV engine sharing the EX ALU, owner of HI/LO.
module muldiv_sequencer #(
  parameter logic [5:0] ADD_CODE = 6'h02,
  parameter logic [5:0] SUB_CODE = 6'h12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_ex,
  input  logic [1:0]  op_ex,
  input  logic [31:0] sourceA_ex,
  input  logic [31:0] sourceB_ex,
  input  logic        flush_ex,
  input  logic        mthi_ex,
  input  logic        mtlo_ex,
  input  logic [31:0] wdata_ex,
  input  logic [31:0] alu_res,
  output logic        alu_req_md,
  output logic [5:0]  alu_control_md,
  output logic [31:0] alu_a_md,
  output logic [31:0] alu_b_md,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] acc_hi, acc_lo, m, a, b, r_sh, hi_nx, lo_nx, fix_hi, fix_lo, mag_a, mag_b;
  logic [63:0] prod;
  logic [4:0] cnt;
  logic is_div, sa, sb, dz, t, c, w, q, open, accept, dz_start, neg_a, neg_b, iter;
  always_comb begin
    iter = state == ITER;
    open = state == IDLE || state == DONE;
    accept = open && start_ex && !flush_ex;
    neg_a = op_ex[0] && sourceA_ex[31];
    neg_b = op_ex[0] && sourceB_ex[31];
    mag_a = neg_a ? -sourceA_ex : sourceA_ex;
    mag_b = neg_b ? -sourceB_ex : sourceB_ex;
    dz_start = op_ex[1] && sourceB_ex == 32'h0;
    r_sh = {acc_hi[30:0], acc_lo[31]};
    t = acc_hi[31];
    a = is_div ? r_sh : acc_hi;
    b = is_div || acc_lo[0] ? m : 32'h0;
    // carry/borrow recovered from operand and result sign bits, since the ALU exposes only 32 bits
    c = (a[31] & b[31]) | ((a[31] | b[31]) & ~alu_res[31]);
    w = (~a[31] & b[31]) | (~(a[31] ^ b[31]) & alu_res[31]);
    q = t | ~w;
    hi_nx = is_div ? (q ? alu_res : r_sh) : {c, alu_res[31:1]};
    lo_nx = is_div ? {acc_lo[30:0], q} : {alu_res[0], acc_lo[31:1]};
    prod = sa ^ sb ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    fix_hi = is_div ? (sa ? -acc_hi : acc_hi) : prod[63:32];
    fix_lo = is_div ? (sa ^ sb ? -acc_lo : acc_lo) : prod[31:0];
    state_nx = flush_ex ? IDLE : accept ? (dz_start ? DONE : ITER) :
               iter ? (cnt == 5'd31 ? FIX : ITER) : state == FIX ? DONE : IDLE;
    alu_req_md = iter;
    alu_control_md = iter && is_div ? SUB_CODE : ADD_CODE;
    alu_a_md = iter ? a : 32'h0;
    alu_b_md = iter ? b : 32'h0;
    busy = iter || state == FIX;
    done = state == DONE;
    div_by_zero = done && dz;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      is_div <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      cnt <= 5'd0;
      acc_hi <= 32'h0;
      acc_lo <= 32'h0;
      m <= 32'h0;
      hi_out <= 32'h0;
      lo_out <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        is_div <= op_ex[1];
        sa <= neg_a;
        sb <= neg_b;
        dz <= dz_start;
        cnt <= 5'd0;
        acc_hi <= 32'h0;
        acc_lo <= op_ex[1] ? mag_a : mag_b;
        m <= op_ex[1] ? mag_b : mag_a;
      end else if (iter) begin
        cnt <= cnt + 5'd1;
        acc_hi <= hi_nx;
        acc_lo <= lo_nx;
      end
      if (open && !flush_ex && mthi_ex) hi_out <= wdata_ex;
      if (open && !flush_ex && mtlo_ex) lo_out <= wdata_ex;
      if (accept && dz_start) begin
        hi_out <= sourceA_ex;
        lo_out <= 32'hFFFF_FFFF;
      end
      if (state == FIX && !flush_ex) begin
        hi_out <= fix_hi;
        lo_out <= fix_lo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks against a timeline/arithmetic model of HI/LO results.
module tb_muldiv_sequencer;
  localparam logic [5:0] ADD = 6'h02;
  localparam logic [5:0] SUB = 6'h12;
  logic clk = 1'b0, reset_n = 1'b1, start_ex = 1'b0, flush_ex = 1'b0, mthi_ex = 1'b0, mtlo_ex = 1'b0;
  logic [1:0] op_ex = 2'd0;
  logic [31:0] sourceA_ex = 32'h0, sourceB_ex = 32'h0, wdata_ex = 32'h0, alu_res;
  logic alu_req_md, busy, done, div_by_zero;
  logic [5:0] alu_control_md;
  logic [31:0] alu_a_md, alu_b_md, hi_out, lo_out;
  int checks = 0, errors = 0;
  int lat, reqs;

  muldiv_sequencer #(.ADD_CODE(ADD), .SUB_CODE(SUB)) dut (
    .clk(clk), .reset_n(reset_n), .start_ex(start_ex), .op_ex(op_ex),
    .sourceA_ex(sourceA_ex), .sourceB_ex(sourceB_ex), .flush_ex(flush_ex),
    .mthi_ex(mthi_ex), .mtlo_ex(mtlo_ex), .wdata_ex(wdata_ex), .alu_res(alu_res),
    .alu_req_md(alu_req_md), .alu_control_md(alu_control_md), .alu_a_md(alu_a_md),
    .alu_b_md(alu_b_md), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;
  assign alu_res = alu_control_md == ADD ? alu_a_md + alu_b_md :
                   alu_control_md == SUB ? alu_a_md - alu_b_md : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, qq, rr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p = 64'h0;
    if (op[1] && b == 32'h0) begin
      dz = 1'b1;
      p = {a, 32'hFFFF_FFFF};
    end else if (op == 2'd0) p = {32'h0, a} * {32'h0, b};
    else if (op == 2'd1) p = sa * sb;
    else if (op == 2'd2) p = {a % b, a / b};
    else begin
      qq = sa / sb;
      rr = sa % sb;
      p = {rr[31:0], qq[31:0]};
    end
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // k counts cycles since the accepting edge: 1..32 ALU use, 33 fix-up, 34 done (1 for divide-by-zero)
  typedef struct {
    int k;
    logic dz, div;
    logic [31:0] hi, lo, rhi, rlo;
  } mdl_t;
  mdl_t md = '{-1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};

  function automatic mdl_t step(input mdl_t s);
    mdl_t n;
    logic [31:0] ph, pl;
    logic pz;
    n = s;
    if (flush_ex) n.k = -1;
    else if (s.k < 0 || s.k == (s.dz ? 1 : 34)) begin
      n.k = -1;
      if (mthi_ex) n.hi = wdata_ex;
      if (mtlo_ex) n.lo = wdata_ex;
      if (start_ex) begin
        ref_op(op_ex, sourceA_ex, sourceB_ex, ph, pl, pz);
        n.k = 1;
        n.dz = pz;
        n.div = op_ex[1];
        n.rhi = ph;
        n.rlo = pl;
        if (pz) begin
          n.hi = ph;
          n.lo = pl;
        end
      end
    end else begin
      n.k = s.k + 1;
      if (n.k == 34) begin
        n.hi = s.rhi;
        n.lo = s.rlo;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) md <= '{-1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    else md <= step(md);

  logic e_req, e_busy, e_done;
  logic [5:0] e_ctrl;
  assign e_req = !md.dz && md.k >= 1 && md.k <= 32;
  assign e_busy = !md.dz && md.k >= 1 && md.k <= 33;
  assign e_done = md.k == (md.dz ? 1 : 34);
  assign e_ctrl = e_req && md.div ? SUB : ADD;

  always @(negedge clk)
    if (reset_n) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("div_by_zero", div_by_zero, e_done && md.dz);
      chk("alu_req_md", alu_req_md, e_req);
      chk("alu_control_md", alu_control_md, e_ctrl);
      chk("hi_out", hi_out, md.hi);
      chk("lo_out", lo_out, md.lo);
    end

  task automatic op_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mt_at, output int l, output int r);
    start_ex = 1'b1;
    op_ex = op;
    sourceA_ex = a;
    sourceB_ex = b;
    @(negedge clk);
    start_ex = 1'b0;
    l = 1;
    r = 0;
    while (!done && l < 100) begin
      if (alu_req_md) r++;
      mthi_ex = l == mt_at;
      wdata_ex = 32'hA5A5;
      @(negedge clk);
      l++;
    end
    mthi_ex = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen after %0d cycles, required within 100", l);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ph, pl;
    logic pz;
    #1 reset_n = 1'b0;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst dz", div_by_zero, 1'b0);
    chk("rst req", alu_req_md, 1'b0);
    chk("rst ctrl", alu_control_md, ADD);
    chk("rst alu_a", alu_a_md, 32'h0);
    chk("rst alu_b", alu_b_md, 32'h0);
    chk("rst hi", hi_out, 32'h0);
    chk("rst lo", lo_out, 32'h0);
    ref_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, ph, pl, pz);
    chk("model div min/-1", {ph, pl}, 64'h0000_0000_8000_0000);
    ref_op(2'd1, 32'hFFFF_FFF9, 32'd6, ph, pl, pz);
    chk("model mult -7*6", {ph, pl}, 64'hFFFF_FFFF_FFFF_FFD6);
    ref_op(2'd3, 32'hFFFF_FFF9, 32'd2, ph, pl, pz);
    chk("model div -7/2", {ph, pl}, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    op_run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, reqs);
    chk("multu latency", lat, 34);
    chk("multu alu_req cycles", reqs, 32);
    chk("multu hi", hi_out, 32'hFFFF_FFFE);
    chk("multu lo", lo_out, 32'h0000_0001);
    @(negedge clk);
    op_run(2'd1, 32'hFFFF_FFF9, 32'd6, 0, lat, reqs);
    chk("mult hi", hi_out, 32'hFFFF_FFFF);
    chk("mult lo", lo_out, 32'hFFFF_FFD6);
    @(negedge clk);
    op_run(2'd3, 32'hFFFF_FFF9, 32'd2, 0, lat, reqs);
    chk("div hi", hi_out, 32'hFFFF_FFFF);
    chk("div lo", lo_out, 32'hFFFF_FFFD);
    op_run(2'd2, 32'd100, 32'd7, 0, lat, reqs);
    chk("back-to-back latency", lat, 34);
    chk("divu hi", hi_out, 32'd2);
    chk("divu lo", lo_out, 32'd14);
    @(negedge clk);
    op_run(2'd2, 32'h1234, 32'h0, 0, lat, reqs);
    chk("dz latency", lat, 1);
    chk("dz flag", div_by_zero, 1'b1);
    chk("dz hi", hi_out, 32'h1234);
    chk("dz lo", lo_out, 32'hFFFF_FFFF);
    @(negedge clk);
    start_ex = 1'b1;
    op_ex = 2'd1;
    sourceA_ex = 32'd12345;
    sourceB_ex = 32'hFFFF_0000;
    @(negedge clk);
    start_ex = 1'b0;
    repeat (9) @(negedge clk);
    flush_ex = 1'b1;
    @(negedge clk);
    flush_ex = 1'b0;
    chk("flush busy", busy, 1'b0);
    chk("flush done", done, 1'b0);
    chk("flush hi kept", hi_out, 32'h1234);
    chk("flush lo kept", lo_out, 32'hFFFF_FFFF);
    op_run(2'd0, 32'd3, 32'd5, 0, lat, reqs);
    chk("after flush latency", lat, 34);
    chk("after flush hi", hi_out, 32'h0);
    chk("after flush lo", lo_out, 32'd15);
    @(negedge clk);
    op_run(2'd0, 32'd2, 32'd3, 6, lat, reqs);
    chk("mthi busy ignored hi", hi_out, 32'h0);
    chk("mthi busy lo", lo_out, 32'd6);
    @(negedge clk);
    mthi_ex = 1'b1;
    wdata_ex = 32'hA5A5;
    @(negedge clk);
    mthi_ex = 1'b0;
    chk("mthi idle hi", hi_out, 32'hA5A5);
    chk("mthi idle lo", lo_out, 32'd6);
    start_ex = 1'b1;
    op_ex = 2'd3;
    sourceA_ex = 32'd999;
    sourceB_ex = 32'd4;
    @(negedge clk);
    start_ex = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst req", alu_req_md, 1'b0);
    chk("async rst alu_a", alu_a_md, 32'h0);
    chk("async rst ctrl", alu_control_md, ADD);
    chk("async rst hi", hi_out, 32'h0);
    chk("async rst lo", lo_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4000) begin
      @(negedge clk);
      start_ex = $urandom % 3 == 0;
      op_ex = 2'($urandom % 4);
      sourceA_ex = pick();
      sourceB_ex = pick();
      flush_ex = $urandom % 150 == 0;
      mthi_ex = $urandom % 10 == 0;
      mtlo_ex = $urandom % 10 == 0;
      wdata_ex = $urandom;
    end
    @(negedge clk);
    {start_ex, flush_ex, mthi_ex, mtlo_ex} = 4'b0;
    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared 32-bit EX-stage ALU for one add or subtract per cycle, one bit per iteration, and owns the architectural HI/LO registers. It sits beside the ALU in EX. While it owns the ALU, the pipeline stalls on `busy`, and the EX operand mux selects the sequencer's ALU drive via `alu_req_md`.

## Interface

Parameters:
- `ADD_CODE`, default 6'h02: ALU control code for ADD.
- `SUB_CODE`, default 6'h12: ALU control code for SUB.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start_ex`  in  1: request an operation; sampled only in IDLE or DONE.
- `op_ex`  in  2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `sourceA_ex`, `sourceB_ex`  in  32 each: A is multiplicand/dividend; B is multiplier/divisor.
- `flush_ex`  in  1: abort any operation in flight.
- `mthi_ex`, `mtlo_ex`  in  1 each: write `wdata_ex` into HI/LO.
- `wdata_ex`  in  32: MTHI/MTLO data.
- `alu_res`  in  32: `res_ex` from the shared ALU, same cycle.
- `alu_req_md`  out  1: sequencer owns the ALU this cycle.
- `alu_control_md`  out  6: ALU operation code.
- `alu_a_md`, `alu_b_md`  out  32 each: ALU operands (ALU `sourceA_ex`/`sourceB_ex1`).
- `busy`  out  1: operation in flight; pipeline stall request.
- `done`  out  1: one-cycle pulse; HI/LO hold the new result.
- `div_by_zero`  out  1: pulses with `done` when a DIV/DIVU had a zero divisor.
- `hi_out`, `lo_out`  out  32 each: architectural HI/LO.

## Operation

- States: IDLE, ITER, FIX, DONE. Reset puts the block in IDLE with every output 0, `hi_out`/`lo_out` = 0 and `alu_control_md` = `ADD_CODE`.
- Working registers: `acc_hi`, `acc_lo`, operand magnitude `m`, sign flags and a 5-bit iteration counter. These are separate from HI/LO.
- Start is accepted from IDLE or DONE (IDLE/DONE with `start_ex`=1):
  - latch `op_ex`;
  - for signed ops, form the magnitudes of A and B locally (two's-complement negate when bit 31 is set) and record sign(A) and sign(B);
  - clear the counter and go to ITER.
- `start_ex` while `busy` is ignored.
- Divide by zero (DIV/DIVU with B = 0): skip ITER and go straight to DONE. Result is HI = A as presented and LO = 32'hFFFF_FFFF, with `div_by_zero`=1 alongside `done`.
- MULT ITER setup: at start, `acc_hi`=0, `acc_lo`=|B|, `m`=|A|. Each cycle:
  - ALU drive: ADD with a=`acc_hi`, b=(`acc_lo`[0] ? `m` : 0).
  - Carry c = (a31&b31) | ((a31|b31)&~res31).
  - Update `acc_hi`={c,res[31:1]}, `acc_lo`={res[0],`acc_lo`[31:1]}.
- DIV ITER setup: at start, `acc_hi`=0, `acc_lo`=|A|, `m`=|B|. Each cycle:
  - Form r'={`acc_hi`[30:0],`acc_lo`[31]} and keep the shifted-out bit t=`acc_hi`[31].
  - ALU drive: SUB with a=r', b=`m`.
  - Borrow w = (~a31&b31) | (~(a31^b31)&res31).
  - q = t | ~w. Update `acc_hi`= q ? res : r', and `acc_lo`={`acc_lo`[30:0],q}.
- ITER runs exactly 32 cycles (counter 0..31), then goes to FIX.
- FIX (no ALU use):
  - MULT: negate the 64-bit {`acc_hi`,`acc_lo`} if sign(A)≠sign(B).
  - DIV: negate the quotient (`acc_lo`) if signs differ; negate the remainder (`acc_hi`) if sign(A)=1.
  - Write HI/LO at the end of FIX, then go to DONE.
- DONE lasts one cycle with `done`=1. It then goes to IDLE, or straight to ITER if `start_ex`=1.
- `flush_ex` (any state, highest priority): go to IDLE on the next edge. HI/LO are unchanged, no `done`, and `start_ex` in the same cycle is ignored.
- MTHI/MTLO:
  - Honoured in IDLE and DONE only; ignored while `busy`.
  - If `mt*` coincides with an accepted start, the write happens and the later result overwrites it.
  - If `mt*` is asserted in DONE, the write wins over the value just produced.

## Timing

- `alu_req_md`=1 only in ITER. ALU operands and code are combinational from state; `alu_res` is consumed in the same cycle.
- `busy`=1 in ITER and FIX, and 0 in IDLE and DONE.
- Cycle 0 is the cycle in which the start is accepted. For a normal op:
  - ITER occupies cycles 1–32;
  - FIX is cycle 33;
  - `done` is high in cycle 34 with the new HI/LO visible.
  - Total latency is 34 cycles.
- Divide by zero: `done` and `div_by_zero` are high in cycle 1.
- Back-to-back: a start accepted in DONE (cycle 34) has its first ITER cycle at 35.
- `reset_n` low at any time forces IDLE and zeroes all outputs, HI and LO asynchronously.

## Test plan

- MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF → `done` at cycle 34; HI=32'hFFFF_FFFE, LO=32'h0000_0001; `alu_req_md` high for exactly 32 cycles.
- MULT A=-7 (32'hFFFF_FFF9), B=6 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFD6.
- DIV A=-7, B=2 → LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). DIVU A=100, B=7 → LO=14, HI=2.
- DIVU B=0, A=32'h1234 → `done` and `div_by_zero` in cycle 1; HI=32'h1234, LO=32'hFFFF_FFFF.
- Start MULT, assert `flush_ex` in cycle 10 → IDLE at cycle 11, `busy`=0, no `done`, HI/LO keep prior values; a new `start_ex` in cycle 11 completes normally.
- `reset_n` pulled low mid-ITER → all outputs 0 immediately. Separately: MTHI 32'hA5A5 while `busy` is ignored; MTHI 32'hA5A5 in IDLE gives `hi_out`=32'hA5A5 next cycle.
